reg_timeout_guard: RTL and testbench



---
 rtl/reg_timeout_guard_pkg.sv | 29 ++
 rtl/reg_timeout_guard_sat_counter.sv | 23 ++
 rtl/reg_timeout_guard.sv | 114 +++++++++++
 tb/tb_reg_timeout_guard.sv | 389 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_timeout_guard_pkg.sv
// Shared types and constants for the register-bus timeout guard.
// reg_req_t / reg_rsp_t mirror the reg_pkg register bus structs.
package reg_timeout_guard_pkg;

    localparam int unsigned CNT_W = 16;
    localparam logic [31:0] ABORT_RDATA_DEFAULT = 32'hBADC_AB1E;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ABORT,
        ST_RECOVER
    } guard_state_e;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic        valid;
    } reg_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        error;
        logic        ready;
    } reg_rsp_t;

endpackage

// File: rtl/reg_timeout_guard_sat_counter.sv
// Saturating up-counter with synchronous clear; clear and increment in
// the same cycle yields 1 (clear first, then count).
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? WIDTH'(1) : '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/reg_timeout_guard.sv
// Register-bus guard: transparent passthrough that aborts accesses stalled
// for TimeoutCycles cycles with an error response, and records statistics.
module reg_timeout_guard
    import reg_timeout_guard_pkg::*;
#(
    parameter int unsigned TimeoutCycles = 1024,
    parameter logic [31:0] AbortRdata    = ABORT_RDATA_DEFAULT,
    parameter type         req_t         = reg_req_t,
    parameter type         rsp_t         = reg_rsp_t
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        en_i,
    input  logic        clear_i,
    input  req_t        up_req_i,
    output rsp_t        up_rsp_o,
    output req_t        dn_req_o,
    input  rsp_t        dn_rsp_i,
    output logic        intr_timeout_o,
    output logic [15:0] timeout_cnt_o,
    output logic [31:0] last_addr_o
);

    guard_state_e     state;
    guard_state_e     next_state;
    logic [CNT_W-1:0] stall_cnt;
    logic             stall_hit;
    logic             abort_now;

    assign stall_hit = (stall_cnt == CNT_W'(TimeoutCycles));
    assign abort_now = (state == ST_ABORT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (en_i && up_req_i.valid && !dn_rsp_i.ready) begin
                    next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (dn_rsp_i.ready || !up_req_i.valid || !en_i) begin
                    next_state = ST_IDLE;
                end else if (stall_hit) begin
                    next_state = ST_ABORT;
                end
            end
            ST_ABORT:   next_state = ST_RECOVER;
            ST_RECOVER: next_state = ST_IDLE;
            default:    next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        dn_req_o = up_req_i;
        up_rsp_o = dn_rsp_i;
        case (state)
            ST_ABORT: begin
                dn_req_o.valid = 1'b0;
                up_rsp_o.ready = 1'b1;
                up_rsp_o.error = 1'b1;
                up_rsp_o.rdata = AbortRdata;
            end
            ST_RECOVER: begin
                dn_req_o.valid = 1'b0;
                up_rsp_o.ready = 1'b0;
            end
            default: ;
        endcase
    end

    // Stall counter is held at 0 outside WAIT, so entering WAIT lands on 1.
    sat_counter #(
        .WIDTH(CNT_W)
    ) u_stall_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (next_state != ST_WAIT),
        .inc   (next_state == ST_WAIT),
        .count (stall_cnt)
    );

    sat_counter #(
        .WIDTH(CNT_W)
    ) u_timeout_cnt (
        .clk   (clk_i),
        .rst   (rst_i),
        .clr   (clear_i),
        .inc   (abort_now),
        .count (timeout_cnt_o)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            intr_timeout_o <= 1'b0;
            last_addr_o    <= '0;
        end else if (abort_now) begin
            intr_timeout_o <= 1'b1;
            last_addr_o    <= up_req_i.addr;
        end else if (clear_i) begin
            intr_timeout_o <= 1'b0;
            last_addr_o    <= '0;
        end
    end

endmodule

// File: tb/tb_reg_timeout_guard.sv
// Directed self-checking bench for reg_timeout_guard with TimeoutCycles=8.
module tb_reg_timeout_guard;
    import reg_timeout_guard_pkg::*;

    localparam int unsigned TO = 8;
    // Valid rises in cycle 0; IDLE plus WAIT with stall_cnt 1..8 stall, ABORT is cycle 9.
    localparam int ABORT_CYC = TO + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        clr;
    reg_req_t    up_req;
    reg_req_t    dn_req;
    reg_rsp_t    up_rsp;
    reg_rsp_t    dn_rsp;
    logic        intr;
    logic [15:0] tcnt;
    logic [31:0] laddr;

    logic        sat_clr;
    logic        sat_inc;
    logic [15:0] sat_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    reg_timeout_guard #(
        .TimeoutCycles(TO),
        .AbortRdata   (32'hBADC_AB1E)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .en_i          (en),
        .clear_i       (clr),
        .up_req_i      (up_req),
        .up_rsp_o      (up_rsp),
        .dn_req_o      (dn_req),
        .dn_rsp_i      (dn_rsp),
        .intr_timeout_o(intr),
        .timeout_cnt_o (tcnt),
        .last_addr_o   (laddr)
    );

    sat_counter #(
        .WIDTH(16)
    ) u_sat (
        .clk   (clk),
        .rst   (rst),
        .clr   (sat_clr),
        .inc   (sat_inc),
        .count (sat_count)
    );

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [31:0] addr, input logic wr, input logic [31:0] wdata);
        up_req.addr  = addr;
        up_req.write = wr;
        up_req.wdata = wdata;
        up_req.wstrb = 4'hF;
        up_req.valid = 1'b1;
    endtask

    task automatic idle_bus();
        up_req = '0;
        dn_rsp = '0;
    endtask

    // Drives a never-ready read through to the IDLE cycle after RECOVER.
    task automatic do_abort(input logic [31:0] addr, input logic clr_at_abort);
        set_req(addr, 1'b0, 32'h0);
        dn_rsp = '0;
        for (int c = 0; c < ABORT_CYC; c++) next_cycle();
        clr = clr_at_abort;
        next_cycle();
        clr = 1'b0;
        up_req.valid = 1'b0;
        next_cycle();
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        set_req(32'h1234_5678, 1'b1, 32'hFACE_0000);
        dn_rsp.rdata = 32'hCAFE_F00D;
        dn_rsp.error = 1'b1;
        dn_rsp.ready = 1'b0;
        #1;
        total++;
        if ({intr, tcnt, laddr} !== 49'h0) begin
            bad++;
            $display("FAIL reset_status got=%h exp=0", {intr, tcnt, laddr});
        end
        total++;
        if (dn_req !== up_req || up_rsp !== dn_rsp) begin
            bad++;
            $display("FAIL reset_passthru dn_req=%h exp=%h up_rsp=%h exp=%h", dn_req, up_req, up_rsp, dn_rsp);
        end
        rst = 1'b0;
        idle_bus();
        next_cycle();
    endtask

    task automatic test_passthrough_read();
        reg_rsp_t exp;
        exp.rdata = 32'h1357_9BDF;
        exp.error = 1'b0;
        exp.ready = 1'b1;
        set_req(32'h2000_0010, 1'b0, 32'h0);
        dn_rsp = '0;
        for (int c = 0; c <= 3; c++) begin
            if (c == 3) begin
                dn_rsp.ready = 1'b1;
                dn_rsp.rdata = 32'h1357_9BDF;
            end
            @(negedge clk);
            if (c == 3) begin
                total++;
                if (up_rsp !== exp || dn_req.addr !== 32'h2000_0010) begin
                    bad++;
                    $display("FAIL read_fwd got=%h exp=%h addr=%h", up_rsp, exp, dn_req.addr);
                end
            end
            next_cycle();
        end
        idle_bus();
        next_cycle();
        total++;
        if ({intr, tcnt} !== 17'h0) begin
            bad++;
            $display("FAIL read_status got=%h exp=0", {intr, tcnt});
        end
    endtask

    task automatic test_timeout_abort();
        int       seen = -1;
        int       pre_bad = 0;
        reg_rsp_t got = '0;
        reg_rsp_t exp;
        logic     dnv = 1'b1;
        exp.rdata = 32'hBADC_AB1E;
        exp.error = 1'b1;
        exp.ready = 1'b1;
        set_req(32'h2000_0010, 1'b0, 32'h0);
        dn_rsp = '0;
        for (int c = 0; c < 20 && seen < 0; c++) begin
            @(negedge clk);
            if (up_rsp.ready) begin
                seen = c;
                got  = up_rsp;
                dnv  = dn_req.valid;
            end else if (dn_req.valid !== 1'b1) begin
                pre_bad++;
            end
            next_cycle();
        end
        up_req.valid = 1'b0;
        total++;
        if (seen != ABORT_CYC) begin
            bad++;
            $display("FAIL abort_cycle got=%0d exp=%0d", seen, ABORT_CYC);
        end
        total++;
        if (got !== exp || dnv !== 1'b0) begin
            bad++;
            $display("FAIL abort_rsp got=%h dnv=%b exp=%h dnv=0", got, dnv, exp);
        end
        @(negedge clk);
        total++;
        if (dn_req.valid !== 1'b0 || up_rsp.ready !== 1'b0) begin
            bad++;
            $display("FAIL recover_gate dnv=%b rdy=%b exp=0 0", dn_req.valid, up_rsp.ready);
        end
        total++;
        if ({intr, tcnt, laddr} !== {1'b1, 16'd1, 32'h2000_0010}) begin
            bad++;
            $display("FAIL abort_status got=%h exp=%h", {intr, tcnt, laddr}, {1'b1, 16'd1, 32'h2000_0010});
        end
        total++;
        if (pre_bad != 0) begin
            bad++;
            $display("FAIL stall_passthru bad_cycles=%0d exp=0", pre_bad);
        end
        next_cycle();
    endtask

    task automatic test_last_cycle_ready();
        int       early = 0;
        reg_rsp_t exp;
        exp.rdata = 32'h0F0F_0F0F;
        exp.error = 1'b0;
        exp.ready = 1'b1;
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        set_req(32'h2000_0014, 1'b0, 32'h0);
        dn_rsp = '0;
        for (int c = 0; c <= int'(TO); c++) begin
            if (c == int'(TO)) begin
                dn_rsp.ready = 1'b1;
                dn_rsp.rdata = 32'h0F0F_0F0F;
            end
            @(negedge clk);
            if (c == int'(TO)) begin
                total++;
                if (up_rsp !== exp) begin
                    bad++;
                    $display("FAIL last_ready_rsp got=%h exp=%h", up_rsp, exp);
                end
            end else if (up_rsp.ready !== 1'b0) begin
                early++;
            end
            next_cycle();
        end
        idle_bus();
        next_cycle();
        total++;
        if ({intr, tcnt, laddr} !== 49'h0 || early != 0) begin
            bad++;
            $display("FAIL last_ready_status got=%h early=%0d exp=0 0", {intr, tcnt, laddr}, early);
        end
    endtask

    task automatic test_recover_discard();
        reg_rsp_t exp;
        exp.rdata = 32'h0;
        exp.error = 1'b0;
        exp.ready = 1'b1;
        set_req(32'h2000_0018, 1'b0, 32'h0);
        dn_rsp = '0;
        repeat (ABORT_CYC) next_cycle();
        next_cycle();
        up_req.valid = 1'b0;
        dn_rsp.ready = 1'b1;
        dn_rsp.rdata = 32'hDEAD_0001;
        @(negedge clk);
        total++;
        if (up_rsp.ready !== 1'b0 || dn_req.valid !== 1'b0) begin
            bad++;
            $display("FAIL late_ready rdy=%b dnv=%b exp=0 0", up_rsp.ready, dn_req.valid);
        end
        next_cycle();
        set_req(32'h2000_0020, 1'b1, 32'hA5A5_5A5A);
        dn_rsp.ready = 1'b1;
        dn_rsp.rdata = 32'h0;
        @(negedge clk);
        total++;
        if (up_rsp !== exp || dn_req !== up_req) begin
            bad++;
            $display("FAIL write_after got=%h exp=%h dn_req=%h exp=%h", up_rsp, exp, dn_req, up_req);
        end
        next_cycle();
        idle_bus();
        total++;
        if (tcnt !== 16'd1) begin
            bad++;
            $display("FAIL recover_cnt got=%0d exp=1", tcnt);
        end
    endtask

    task automatic test_clear();
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        for (int i = 0; i < 5; i++) do_abort(32'h2000_0100 + 32'(i * 4), 1'b0);
        total++;
        if ({intr, tcnt, laddr} !== {1'b1, 16'd5, 32'h2000_0110}) begin
            bad++;
            $display("FAIL five_aborts got=%h exp=%h", {intr, tcnt, laddr}, {1'b1, 16'd5, 32'h2000_0110});
        end
        do_abort(32'h2000_0200, 1'b1);
        total++;
        if ({intr, tcnt, laddr} !== {1'b1, 16'd1, 32'h2000_0200}) begin
            bad++;
            $display("FAIL clear_with_abort got=%h exp=%h", {intr, tcnt, laddr}, {1'b1, 16'd1, 32'h2000_0200});
        end
        clr = 1'b1;
        next_cycle();
        clr = 1'b0;
        total++;
        if ({intr, tcnt, laddr} !== 49'h0) begin
            bad++;
            $display("FAIL clear_alone got=%h exp=0", {intr, tcnt, laddr});
        end
    endtask

    task automatic test_disabled();
        int       nbad = 0;
        reg_rsp_t exp;
        exp.rdata = 32'h0000_55AA;
        exp.error = 1'b0;
        exp.ready = 1'b1;
        en = 1'b0;
        set_req(32'h2000_0300, 1'b0, 32'h0);
        dn_rsp = '0;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            if (dn_req.valid !== 1'b1 || up_rsp.ready !== 1'b0) nbad++;
            next_cycle();
        end
        dn_rsp.ready = 1'b1;
        dn_rsp.rdata = 32'h0000_55AA;
        @(negedge clk);
        total++;
        if (up_rsp !== exp || nbad != 0) begin
            bad++;
            $display("FAIL disabled_passthru got=%h exp=%h bad_cycles=%0d", up_rsp, exp, nbad);
        end
        next_cycle();
        idle_bus();
        en = 1'b1;
        total++;
        if ({intr, tcnt} !== 17'h0) begin
            bad++;
            $display("FAIL disabled_status got=%h exp=0", {intr, tcnt});
        end
    endtask

    task automatic test_reset_mid_wait();
        do_abort(32'h2000_0400, 1'b0);
        set_req(32'h2000_0404, 1'b0, 32'h0);
        dn_rsp = '0;
        repeat (4) next_cycle();
        #2;
        rst = 1'b1;
        #1;
        total++;
        if (dut.state !== ST_IDLE || {intr, tcnt, laddr} !== 49'h0 || up_rsp.error !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_wait state=%0d status=%h err=%b exp=0 0 0", dut.state, {intr, tcnt, laddr}, up_rsp.error);
        end
        next_cycle();
        rst = 1'b0;
        idle_bus();
        next_cycle();
    endtask

    task automatic test_saturation();
        sat_inc = 1'b1;
        repeat (65534) next_cycle();
        total++;
        if (sat_count !== 16'hFFFE) begin
            bad++;
            $display("FAIL sat_pre got=%h exp=fffe", sat_count);
        end
        repeat (4) next_cycle();
        total++;
        if (sat_count !== 16'hFFFF) begin
            bad++;
            $display("FAIL sat_hold got=%h exp=ffff", sat_count);
        end
        sat_clr = 1'b1;
        next_cycle();
        sat_clr = 1'b0;
        sat_inc = 1'b0;
        total++;
        if (sat_count !== 16'h0001) begin
            bad++;
            $display("FAIL sat_clr_inc got=%h exp=0001", sat_count);
        end
    endtask

    initial begin
        rst     = 1'b1;
        en      = 1'b1;
        clr     = 1'b0;
        sat_clr = 1'b0;
        sat_inc = 1'b0;
        idle_bus();
        test_reset();
        test_passthrough_read();
        test_timeout_abort();
        test_last_cycle_ready();
        test_recover_discard();
        test_clear();
        test_disabled();
        test_reset_mid_wait();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
